fulladder_mux8way: RTL and testbench
====================================

# fulladder_mux8way

Registered N-bit ALU datapath built from a ripple chain of per-bit full adders and per-bit 8-way result multiplexers. It executes one of eight operations on two operands per accepted cycle and registers the result together with carry, zero and overflow flags. It sits between operand registers and writeback as the integer execute stage.

## Interface

Clock/reset: one clock; reset is asynchronous and active-high. Ports are `clk` and `reset`.

Parameters:
- `WIDTH`, default 32: operand and result width in bits; minimum 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all registered outputs.
- `in_valid`  in  1  operands and command are valid this cycle.
- `command`  in  3  operation select.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  registered outputs hold a new result.
- `result`  out  WIDTH  registered result.
- `carryout`  out  1  registered carry out of the MSB adder.
- `zero`  out  1  registered flag, set when `result` is all zeros.
- `overflow`  out  1  registered two's-complement overflow.

## Operation

Command encoding:
- 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.

Arithmetic path:
- `invtb` = 1 for SUB and SLT, 0 otherwise.
- Per bit, b1 = b XOR invtb; carry-in of bit 0 = invtb.
- Full-adder ripple chain computes sum = a + b1 + cin, modulo 2^WIDTH.

Logic path:
- XOR, AND, NAND, NOR and OR use the raw `b`, never the inverted b1.

Per-bit 8-way mux:
- Inputs in order 0..7: sum, sum, xor, sum, and, nand, nor, or.

SLT (with `SLT_EN`):
- result = {WIDTH-1 zeros, sum[MSB] XOR ovf}, i.e. signed a < b.

Flags:
- `carryout` = carry out of the MSB for ADD/SUB/SLT; 0 for logic ops.
- `overflow` = carry into MSB XOR carry out of MSB for ADD/SUB/SLT; 0 for logic ops.
- `zero` = NOR-reduction of the final muxed `result`, not of sum.

## Timing

- Latency 1: when `in_valid`=1 at a rising edge, `result`/`carryout`/`zero`/`overflow` update and `out_valid`=1 after that edge.
- `in_valid`=0 at an edge: `out_valid`=0; result and flag registers hold their previous values.
- Back-to-back inputs are accepted every cycle; no backpressure.
- Reset asserted at any time: all outputs go to 0 immediately (`zero`=0 as well) and any in-flight operation is discarded. The first edge after reset deasserts samples normally.

## Configuration

- `SLT_EN` defined: command 3 performs signed set-less-than as described in Operation.
- `SLT_EN` undefined: command 3 behaves exactly as SUB (result = sum, flags computed as for SUB).

## Test plan

- ADD a=0x7FFFFFFF, b=0x00000001 -> next cycle result=0x80000000, carryout=0, overflow=1, zero=0, out_valid=1.
- SUB a=5, b=5 -> result=0, zero=1, carryout=1, overflow=0.
- SLT a=0xFFFFFFFF, b=1 -> with `SLT_EN` result=1, zero=0; without `SLT_EN` result=0xFFFFFFFE, carryout=1.
- NAND a=0xF0F0F0F0, b=0xFF00FF00 -> result=0x0FFF0FFF, carryout=0, overflow=0. Then XOR with the same operands -> result=0x0FF00FF0.
- `in_valid` pulse for OR 0x1|0x2, followed by an idle cycle -> result=0x3, and stays 0x3 while out_valid drops to 0.
- Assert `reset` mid-stream between clock edges -> all outputs 0 before the next edge. After release, ADD 1+1 -> result=2 one cycle later.

Source files
------------

// File: rtl/fulladder_mux8way.sv
// fulladder_mux8way: registered ripple-carry ALU stage with per-bit 8-way result mux.
// Define SLT_EN to make command 3 a signed set-less-than; otherwise it behaves as SUB.
module fulladder_mux8way #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);
    logic             invtb;
    logic             arith;
    logic             ovf;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] mux;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   c;
    assign invtb = (command == 3'd1) || (command == 3'd3);
    assign arith = (command == 3'd0) || invtb;
    assign b1    = b ^ {WIDTH{invtb}};
    assign c[0]  = invtb;
    assign ovf   = c[WIDTH] ^ c[WIDTH-1];
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic [7:0] sel;
            assign sum[i]   = a[i] ^ b1[i] ^ c[i];
            assign c[i+1]   = (a[i] & b1[i]) | (c[i] & (a[i] ^ b1[i]));
            // Logic ops see the raw b, never the inverted b1.
            assign sel      = {a[i] | b[i], ~(a[i] | b[i]), ~(a[i] & b[i]), a[i] & b[i],
                               sum[i], a[i] ^ b[i], sum[i], sum[i]};
            assign mux[i]   = sel[command];
        end
    endgenerate
`ifdef SLT_EN
    assign res = (command == 3'd3) ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf} : mux;
`else
    assign res = mux;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= res;
                carryout <= arith & c[WIDTH];
                zero     <= ~|res;
                overflow <= arith & ovf;
            end
        end
    end
endmodule

// File: tb/tb_fulladder_mux8way.sv
// tb_fulladder_mux8way: table-driven directed checks of the registered ALU stage.
module tb_fulladder_mux8way;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  command = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        carryout;
    logic        zero;
    logic        overflow;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        string       name;
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        co;
        logic        z;
        logic        ov;
    } vec_t;

    vec_t vecs[16];

    fulladder_mux8way #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .command(command),
        .a(a), .b(b), .out_valid(out_valid), .result(result),
        .carryout(carryout), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic ov_v, input logic [31:0] r,
                           input logic co, input logic z, input logic ov);
        chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov_v});
        chk({name, ".result"}, result, r);
        chk({name, ".carryout"}, {31'd0, carryout}, {31'd0, co});
        chk({name, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({name, ".overflow"}, {31'd0, overflow}, {31'd0, ov});
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] c, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] r,
                                input logic co, input logic z, input logic ov);
        vec_t v;
        v.name = n; v.cmd = c; v.a = va; v.b = vb; v.r = r; v.co = co; v.z = z; v.ov = ov;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk("add_ovf",   3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
        vecs[1]  = mk("sub_eq",    3'd1, 32'd5,        32'd5,        32'h00000000, 1, 1, 0);
`ifdef SLT_EN
        vecs[2]  = mk("slt_m1_1",  3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, 0);
        vecs[3]  = mk("slt_5_3",   3'd3, 32'd5,        32'd3,        32'h00000000, 1, 1, 0);
        vecs[4]  = mk("slt_min_1", 3'd3, 32'h80000000, 32'h00000001, 32'h00000001, 1, 0, 1);
`else
        vecs[2]  = mk("slt_m1_1",  3'd3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1, 0, 0);
        vecs[3]  = mk("slt_5_3",   3'd3, 32'd5,        32'd3,        32'h00000002, 1, 0, 0);
        vecs[4]  = mk("slt_min_1", 3'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1);
`endif
        vecs[5]  = mk("nand",      3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 0, 0, 0);
        vecs[6]  = mk("xor",       3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0);
        vecs[7]  = mk("and",       3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0);
        vecs[8]  = mk("nor_zero",  3'd6, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0);
        vecs[9]  = mk("nor_ones",  3'd6, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 1, 0);
        vecs[10] = mk("or",        3'd7, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0);
        vecs[11] = mk("add_wrap",  3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);
        vecs[12] = mk("sub_borrow",3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0);
        vecs[13] = mk("sub_ovf",   3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1);
        vecs[14] = mk("add_min",   3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1);
        vecs[15] = mk("xor_raw_b", 3'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 chk_all("reset", 0, 32'h0, 0, 0, 0);
        @(negedge clk) reset = 1'b0;

        // Back-to-back: in_valid held high across the whole table.
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; command = vecs[k].cmd; a = vecs[k].a; b = vecs[k].b;
            @(posedge clk);
            #1 chk_all(vecs[k].name, 1, vecs[k].r, vecs[k].co, vecs[k].z, vecs[k].ov);
            @(negedge clk);
        end

        // Single OR pulse then idle: result holds while out_valid drops.
        in_valid = 1'b1; command = 3'd0; a = 32'd7; b = 32'd9;
        @(posedge clk); @(negedge clk);
        command = 3'd7; a = 32'h1; b = 32'h2;
        @(posedge clk); #1 chk_all("or_pulse", 1, 32'h3, 0, 0, 0);
        @(negedge clk) begin in_valid = 1'b0; command = 3'd0; a = 32'hFFFFFFFF; b = 32'h1; end
        @(posedge clk); #1 chk_all("idle1", 0, 32'h3, 0, 0, 0);
        @(posedge clk); #1 chk_all("idle2", 0, 32'h3, 0, 0, 0);

        // Asynchronous reset between edges, then ADD 1+1 after release.
        @(negedge clk) begin in_valid = 1'b1; command = 3'd1; a = 32'd5; b = 32'd5; end
        @(posedge clk); #3 reset = 1'b1;
        #1 chk_all("async_rst", 0, 32'h0, 0, 0, 0);
        @(negedge clk) begin reset = 1'b0; command = 3'd0; a = 32'd1; b = 32'd1; end
        @(posedge clk); #1 chk_all("post_rst_add", 1, 32'h2, 0, 0, 0);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1 chk_all("post_rst_idle", 0, 32'h2, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
